// File: rtl/hazard_flow_ctrl.sv
// Pipeline flow controller: load-use / branch-operand hazard stalls, fetch redirects,
// instruction-memory wait handling and saturating stall/flush counters.
module hazard_flow_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LDBR_STALLS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUsesRt,
    input  logic             idBranch,
    input  logic             branchTaken,
    input  logic             idJump,
    input  logic             exMemRead,
    input  logic             exRegWrite,
    input  logic [4:0]       exDst,
    input  logic             imemReady,
    output logic [1:0]       pcSrc,
    output logic             pcWrite,
    output logic             ifFlush,
    output logic             ifidWrite,
    output logic             idexFlush,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    typedef enum logic [0:0] {StRun, StHold} state_e;

    localparam logic [1:0] HOLD_INIT = (LDBR_STALLS > 1) ? 2'(LDBR_STALLS - 2) : 2'd0;
    localparam bit         USE_HOLD  = (LDBR_STALLS > 1);

    state_e           r_state;
    logic [1:0]       r_holdCnt;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    logic w_exHit;
    logic w_loadUse;
    logic w_brDep;
    logic w_ldBr;
    logic w_stall;

    assign w_exHit   = (exDst != 5'd0) &&
                       ((exDst == idRs) || (idUsesRt && (exDst == idRt)));
    assign w_loadUse = exMemRead && w_exHit;
    assign w_brDep   = idBranch && exRegWrite && w_exHit;
    assign w_ldBr    = w_brDep && exMemRead;
    assign w_stall   = (r_state == StHold) || w_loadUse || w_brDep;

    always_comb begin
        pcSrc     = 2'd0;
        pcWrite   = 1'b0;
        ifFlush   = 1'b0;
        ifidWrite = 1'b0;
        idexFlush = 1'b0;
        if (!rst) begin
            if (w_stall) begin
                idexFlush = 1'b1;
            end else if (idJump) begin
                pcSrc     = 2'd2;
                pcWrite   = 1'b1;
                ifidWrite = 1'b1;
                ifFlush   = 1'b1;
            end else if (idBranch && branchTaken) begin
                pcSrc     = 2'd1;
                pcWrite   = 1'b1;
                ifidWrite = 1'b1;
                ifFlush   = 1'b1;
            end else if (!imemReady) begin
                // Fetch not ready: push a NOP into ID but keep PC.
                ifidWrite = 1'b1;
                ifFlush   = 1'b1;
            end else begin
                pcWrite   = 1'b1;
                ifidWrite = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StRun;
            r_holdCnt  <= 2'd0;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (idexFlush && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + CNT_W'(1);
            if (ifFlush && (r_flushCnt != '1)) r_flushCnt <= r_flushCnt + CNT_W'(1);
            case (r_state)
                StRun: begin
                    if (w_ldBr && USE_HOLD) begin
                        r_state   <= StHold;
                        r_holdCnt <= HOLD_INIT;
                    end
                end
                StHold: begin
                    if (r_holdCnt == 2'd0) r_state <= StRun;
                    else r_holdCnt <= r_holdCnt - 2'd1;
                end
                default: r_state <= StRun;
            endcase
        end
    end

    assign stallCnt = r_stallCnt;
    assign flushCnt = r_flushCnt;

endmodule

// File: tb/tb_hazard_flow_ctrl.sv
// Self-checking bench for hazard_flow_ctrl: vector table, directed corner sequences and
// randomized stimulus against a cycle-level reference model (two parameterisations).
module tb_hazard_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] idRs, idRt, exDst;
    logic       idUsesRt, idBranch, branchTaken, idJump, exMemRead, exRegWrite, imemReady;

    logic [1:0]  ps_a, ps_b;
    logic        pw_a, ff_a, iw_a, xf_a, pw_b, ff_b, iw_b, xf_b;
    logic [3:0]  sc_a, fc_a;
    logic [15:0] sc_b, fc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_flow_ctrl #(.CNT_W(4), .LDBR_STALLS(2)) dut_a (
        .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .idBranch(idBranch), .branchTaken(branchTaken), .idJump(idJump),
        .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exDst(exDst),
        .imemReady(imemReady), .pcSrc(ps_a), .pcWrite(pw_a), .ifFlush(ff_a),
        .ifidWrite(iw_a), .idexFlush(xf_a), .stallCnt(sc_a), .flushCnt(fc_a)
    );

    hazard_flow_ctrl #(.CNT_W(16), .LDBR_STALLS(3)) dut_b (
        .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .idBranch(idBranch), .branchTaken(branchTaken), .idJump(idJump),
        .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exDst(exDst),
        .imemReady(imemReady), .pcSrc(ps_b), .pcWrite(pw_b), .ifFlush(ff_b),
        .ifidWrite(iw_b), .idexFlush(xf_b), .stallCnt(sc_b), .flushCnt(fc_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        idRs = 5'd0; idRt = 5'd0; exDst = 5'd0; idUsesRt = 1'b0; idBranch = 1'b0;
        branchTaken = 1'b0; idJump = 1'b0; exMemRead = 1'b0; exRegWrite = 1'b0;
        imemReady = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic chk_a(input string name, input int ps, input int pw, input int ff,
                         input int iw, input int xf);
        chk({name, ".pcSrc"}, int'(ps_a), ps);
        chk({name, ".pcWrite"}, int'(pw_a), pw);
        chk({name, ".ifFlush"}, int'(ff_a), ff);
        chk({name, ".ifidWrite"}, int'(iw_a), iw);
        chk({name, ".idexFlush"}, int'(xf_a), xf);
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: extra-stall budget per instance ----------------
    int m_left[2];
    int m_sc[2];
    int m_fc[2];
    int m_L[2]   = '{2, 3};
    int m_max[2] = '{15, 65535};

    function automatic bit m_hit();
        return (exDst != 0) && ((exDst == idRs) || (idUsesRt && exDst == idRt));
    endfunction

    task automatic m_out(input int k, output int ps, output int pw, output int ff,
                         output int iw, output int xf);
        bit hit;
        hit = m_hit();
        {ps, pw, ff, iw, xf} = '0;
        if (rst) begin
        end else if (m_left[k] > 0 || (exMemRead && hit) || (idBranch && exRegWrite && hit)) begin
            xf = 1;
        end else if (idJump) begin
            ps = 2; pw = 1; ff = 1; iw = 1;
        end else if (idBranch && branchTaken) begin
            ps = 1; pw = 1; ff = 1; iw = 1;
        end else if (!imemReady) begin
            ff = 1; iw = 1;
        end else begin
            pw = 1; iw = 1;
        end
    endtask

    task automatic m_clock(input int k);
        int ps, pw, ff, iw, xf;
        bit was_hold;
        if (rst) return;
        m_out(k, ps, pw, ff, iw, xf);
        if (xf == 1) m_sc[k] = (m_sc[k] + 1 > m_max[k]) ? m_max[k] : m_sc[k] + 1;
        if (ff == 1) m_fc[k] = (m_fc[k] + 1 > m_max[k]) ? m_max[k] : m_fc[k] + 1;
        was_hold = (m_left[k] > 0);
        if (was_hold) m_left[k]--;
        else if (idBranch && exRegWrite && exMemRead && m_hit()) m_left[k] = m_L[k] - 1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic [4:0] rs, rt, dst;
        logic       uses_rt, br, taken, jmp, mrd, rwr, rdy;
        int         ps, pw, ff, iw, xf;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int eps, epw, eff, eiw, exf;

        //            name        rs rt dst ur br tk jp mr rw rd  ps pw ff iw xf
        vecs[0]  = '{"normal",     1, 2, 3, 1, 0, 0, 0, 0, 1, 1,  0, 1, 0, 1, 0};
        vecs[1]  = '{"lu_rs",      4, 2, 4, 0, 0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 1};
        vecs[2]  = '{"lu_rt",      1, 6, 6, 1, 0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 1};
        vecs[3]  = '{"rt_unused",  1, 6, 6, 0, 0, 0, 0, 1, 1, 1,  0, 1, 0, 1, 0};
        vecs[4]  = '{"reg0",       0, 0, 0, 1, 0, 0, 0, 1, 1, 1,  0, 1, 0, 1, 0};
        vecs[5]  = '{"jump",       1, 2, 3, 0, 0, 0, 1, 0, 0, 0,  2, 1, 1, 1, 0};
        vecs[6]  = '{"br_taken",   1, 2, 3, 1, 1, 1, 0, 0, 1, 1,  1, 1, 1, 1, 0};
        vecs[7]  = '{"br_not",     1, 2, 3, 1, 1, 0, 0, 0, 1, 1,  0, 1, 0, 1, 0};
        vecs[8]  = '{"imem_wait",  1, 2, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0};
        vecs[9]  = '{"br_tk_wait", 1, 2, 3, 1, 1, 1, 0, 0, 0, 0,  1, 1, 1, 1, 0};
        vecs[10] = '{"br_dep_alu", 5, 2, 5, 1, 1, 1, 0, 0, 1, 1,  0, 0, 0, 0, 1};
        vecs[11] = '{"lu_vs_jmp",  7, 2, 7, 0, 0, 0, 1, 1, 1, 1,  0, 0, 0, 0, 1};

        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            do_reset();
            idRs = vecs[i].rs; idRt = vecs[i].rt; exDst = vecs[i].dst;
            idUsesRt = vecs[i].uses_rt; idBranch = vecs[i].br; branchTaken = vecs[i].taken;
            idJump = vecs[i].jmp; exMemRead = vecs[i].mrd; exRegWrite = vecs[i].rwr;
            imemReady = vecs[i].rdy;
            #1;
            chk_a(vecs[i].name, vecs[i].ps, vecs[i].pw, vecs[i].ff, vecs[i].iw, vecs[i].xf);
        end

        // Reset mid-stream, then release into normal fetch.
        set_idle(); idJump = 1'b1; imemReady = 1'b0;
        tick();
        rst = 1'b1; #1;
        chk_a("rst_hold", 0, 0, 0, 0, 0);
        chk("rst_hold.stallCnt", int'(sc_a), 0);
        chk("rst_hold.flushCnt", int'(fc_a), 0);
        tick();
        set_idle(); rst = 1'b0; #1;
        chk_a("rst_rel", 0, 1, 0, 1, 0);

        // Load-use: single stall cycle.
        do_reset();
        exMemRead = 1'b1; exDst = 5'd8; idRs = 5'd8; #1;
        chk_a("lu_c0", 0, 0, 0, 0, 1);
        tick();
        exMemRead = 1'b0; #1;
        chk_a("lu_c1", 0, 1, 0, 1, 0);
        chk("lu.stallCnt", int'(sc_a), 1);

        // Load-branch: HOLD ignores redirects.
        do_reset();
        set_idle();
        exMemRead = 1'b1; exRegWrite = 1'b1; exDst = 5'd9; idBranch = 1'b1;
        idRt = 5'd9; idUsesRt = 1'b1; #1;
        chk_a("ldbr_c0", 0, 0, 0, 0, 1);
        tick();
        exMemRead = 1'b0; exRegWrite = 1'b0; exDst = 5'd0;
        branchTaken = 1'b1; idJump = 1'b1; #1;
        chk_a("ldbr_hold", 0, 0, 0, 0, 1);
        tick();
        idJump = 1'b0; #1;
        chk_a("ldbr_after", 1, 1, 1, 1, 0);
        chk("ldbr.stallCnt", int'(sc_a), 2);

        // Register zero never hazards; jump redirect counts one flush.
        do_reset();
        set_idle();
        exMemRead = 1'b1; exDst = 5'd0; idRs = 5'd0; idJump = 1'b1; #1;
        chk_a("r0_jmp", 2, 1, 1, 1, 0);
        tick();
        chk("r0_jmp.flushCnt", int'(fc_a), 1);

        // Instruction memory wait for three cycles.
        do_reset();
        set_idle();
        imemReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_a($sformatf("imem_w%0d", c), 0, 0, 1, 1, 0);
            tick();
        end
        chk("imem.flushCnt", int'(fc_a), 3);
        idBranch = 1'b1; branchTaken = 1'b1; #1;
        chk_a("imem_br", 1, 1, 1, 1, 0);

        // Saturation at 4-bit width, then reset abort from HOLD.
        do_reset();
        set_idle();
        exMemRead = 1'b1; exDst = 5'd3; idRs = 5'd3;
        repeat (20) tick();
        chk("sat.stallCnt", int'(sc_a), 15);
        exRegWrite = 1'b1; idBranch = 1'b1;
        tick();
        set_idle();
        #1;
        chk("hold_entered.idexFlush", int'(xf_a), 1);
        rst = 1'b1; #1; rst = 1'b0; #1;
        chk_a("rst_abort", 0, 1, 0, 1, 0);

        // Randomized run against the model, both parameterisations.
        set_idle();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(59) == 0);
            idRs        = 5'($urandom_range(3));
            idRt        = 5'($urandom_range(3));
            exDst       = 5'($urandom_range(3));
            idUsesRt    = 1'($urandom);
            idBranch    = 1'($urandom);
            branchTaken = 1'($urandom);
            idJump      = ($urandom_range(4) == 0);
            exMemRead   = 1'($urandom);
            exRegWrite  = 1'($urandom);
            imemReady   = ($urandom_range(3) != 0);
            #1;
            if (rst) begin
                for (int k = 0; k < 2; k++) begin
                    m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
                end
            end
            m_out(0, eps, epw, eff, eiw, exf);
            chk("rnd_a", {ps_a, pw_a, ff_a, iw_a, xf_a}, {eps[1:0], epw[0], eff[0], eiw[0], exf[0]});
            chk("rnd_a.stallCnt", int'(sc_a), m_sc[0]);
            chk("rnd_a.flushCnt", int'(fc_a), m_fc[0]);
            m_out(1, eps, epw, eff, eiw, exf);
            chk("rnd_b", {ps_b, pw_b, ff_b, iw_b, xf_b}, {eps[1:0], epw[0], eff[0], eiw[0], exf[0]});
            chk("rnd_b.stallCnt", int'(sc_b), m_sc[1]);
            chk("rnd_b.flushCnt", int'(fc_b), m_fc[1]);
            @(posedge clk);
            m_clock(0);
            m_clock(1);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
